// File: rtl/wave_sequencer.sv
// ============================================================================
// Module      : wave_sequencer
// Description : Loadable prescaler plus 4-slot (wave_sel, dwell) sequencer
//               driving the waveform generator's select and step-enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_sequencer #(
    parameter int DIV_WIDTH   = 24,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_addr,
    input  logic [1:0]             cfg_sel,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [1:0]             cfg_last,
    input  logic                   loop_en,
    input  logic [DIV_WIDTH-1:0]   div_load,
    input  logic                   start,
    input  logic                   stop,
    output logic [1:0]             wave_sel,
    output logic                   tick,
    output logic [1:0]             slot,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0]             c_IDLE    = 2'd0;
    localparam logic [1:0]             c_RUN     = 2'd1;
    localparam logic [1:0]             c_FINISH  = 2'd2;
    localparam logic [1:0]             c_SEL_OFF = 2'b11;
    localparam logic [DWELL_WIDTH-1:0] c_DWELL_1 = DWELL_WIDTH'(1);

    logic [1:0]             r_state;
    logic [1:0]             r_slot;
    logic [1:0]             r_wave_sel;
    logic [1:0]             r_last;
    logic                   r_loop;
    logic [DIV_WIDTH-1:0]   r_div_load;
    logic [DIV_WIDTH-1:0]   r_div_cnt;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt;
    logic [1:0]             r_tbl_sel   [4];
    logic [DWELL_WIDTH-1:0] r_tbl_dwell [4];

    logic                   w_tick;
    logic [DWELL_WIDTH-1:0] w_cur_dwell;
    logic                   w_dwell_end;
    logic [1:0]             w_next_slot;

    assign w_tick      = (r_state == c_RUN) && (r_div_cnt == r_div_load);
    assign w_cur_dwell = r_tbl_dwell[r_slot];
    // A zero dwell is played as a single tick.
    assign w_dwell_end = (w_cur_dwell == '0) || (r_dwell_cnt == w_cur_dwell - c_DWELL_1);
    assign w_next_slot = r_slot + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_slot      <= 2'd0;
            r_wave_sel  <= c_SEL_OFF;
            r_last      <= 2'd0;
            r_loop      <= 1'b0;
            r_div_load  <= '0;
            r_div_cnt   <= '0;
            r_dwell_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                r_tbl_sel[i]   <= c_SEL_OFF;
                r_tbl_dwell[i] <= c_DWELL_1;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cfg_we) begin
                        r_tbl_sel[cfg_addr]   <= cfg_sel;
                        r_tbl_dwell[cfg_addr] <= cfg_dwell;
                    end
                    if (start && !stop) begin
                        r_state     <= c_RUN;
                        r_last      <= cfg_last;
                        r_loop      <= loop_en;
                        r_div_load  <= div_load;
                        r_slot      <= 2'd0;
                        r_wave_sel  <= r_tbl_sel[0];
                        r_div_cnt   <= '0;
                        r_dwell_cnt <= '0;
                    end
                end
                c_RUN: begin
                    if (stop) begin
                        r_state    <= c_IDLE;
                        r_slot     <= 2'd0;
                        r_wave_sel <= c_SEL_OFF;
                    end else if (w_tick) begin
                        r_div_cnt <= '0;
                        if (w_dwell_end) begin
                            r_dwell_cnt <= '0;
                            if (r_slot < r_last) begin
                                r_slot     <= w_next_slot;
                                r_wave_sel <= r_tbl_sel[w_next_slot];
                            end else if (r_loop) begin
                                r_slot     <= 2'd0;
                                r_wave_sel <= r_tbl_sel[0];
                            end else begin
                                r_state    <= c_FINISH;
                                r_slot     <= 2'd0;
                                r_wave_sel <= c_SEL_OFF;
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + c_DWELL_1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
                    end
                end
                c_FINISH: r_state <= c_IDLE;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    assign wave_sel = r_wave_sel;
    assign tick     = w_tick;
    assign slot     = r_slot;
    assign busy     = (r_state == c_RUN);
    assign done     = (r_state == c_FINISH);

endmodule

`default_nettype wire

// File: tb/tb_wave_sequencer.sv
// ============================================================================
// Module      : tb_wave_sequencer
// Description : Scoreboard bench for wave_sequencer; a countdown-style
//               reference model queues per-cycle expected outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wave_sequencer;

    localparam int DIV_W = 4;
    localparam int DW_W  = 8;

    logic            clk      = 1'b0;
    logic            reset    = 1'b1;
    logic            cfg_we   = 1'b0;
    logic [1:0]      cfg_addr = 2'd0;
    logic [1:0]      cfg_sel  = 2'd0;
    logic [DW_W-1:0] cfg_dwell = '0;
    logic [1:0]      cfg_last = 2'd0;
    logic            loop_en  = 1'b0;
    logic [DIV_W-1:0] div_load = '0;
    logic            start    = 1'b0;
    logic            stop     = 1'b0;
    logic [1:0]      wave_sel;
    logic            tick;
    logic [1:0]      slot;
    logic            busy;
    logic            done;

    wave_sequencer #(.DIV_WIDTH(DIV_W), .DWELL_WIDTH(DW_W)) u_dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_sel(cfg_sel), .cfg_dwell(cfg_dwell), .cfg_last(cfg_last),
        .loop_en(loop_en), .div_load(div_load), .start(start), .stop(stop),
        .wave_sel(wave_sel), .tick(tick), .slot(slot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: counts down cycles-to-tick and ticks-left-in-slot.
    int         m_state;
    logic [1:0] m_slot, m_sel, m_last;
    bit         m_loop;
    int         m_div, m_pre_left, m_ticks_left;
    logic [1:0] m_tsel [4];
    int         m_tdw  [4];
    logic [6:0] sb_q [$];

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_slot = 2'd0; m_sel = 2'b11;
            m_pre_left = 0; m_ticks_left = 1; m_div = 0; m_last = 2'd0; m_loop = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_tsel[i] = 2'b11;
                m_tdw[i]  = 1;
            end
            sb_q.delete();
        end else begin
            case (m_state)
                0: begin
                    if (start && !stop) begin
                        m_state = 1; m_last = cfg_last; m_loop = loop_en;
                        m_div = int'(div_load); m_pre_left = int'(div_load);
                        m_slot = 2'd0; m_sel = m_tsel[0]; m_ticks_left = eff(m_tdw[0]);
                    end
                    if (cfg_we) begin
                        m_tsel[cfg_addr] = cfg_sel;
                        m_tdw[cfg_addr]  = int'(cfg_dwell);
                    end
                end
                1: begin
                    if (stop) begin
                        m_state = 0; m_slot = 2'd0; m_sel = 2'b11;
                    end else if (m_pre_left == 0) begin
                        m_pre_left = m_div;
                        m_ticks_left--;
                        if (m_ticks_left == 0) begin
                            if (m_slot < m_last) m_slot = m_slot + 2'd1;
                            else if (m_loop) m_slot = 2'd0;
                            else begin
                                m_state = 2; m_slot = 2'd0; m_sel = 2'b11;
                            end
                            if (m_state == 1) begin
                                m_sel = m_tsel[m_slot];
                                m_ticks_left = eff(m_tdw[m_slot]);
                            end
                        end
                    end else begin
                        m_pre_left--;
                    end
                end
                default: m_state = 0;
            endcase
        end
        sb_q.push_back({m_sel, (m_state == 1 && m_pre_left == 0), m_slot,
                        (m_state == 1), (m_state == 2)});
    end

    int done_cnt = 0;
    int gap      = 0;
    int exp_gap  = 0;

    always @(negedge clk) begin
        logic [6:0] e_out;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e_out = sb_q.pop_front();
            check("outputs{sel,tick,slot,busy,done}", {25'd0, wave_sel, tick, slot, busy, done}, {25'd0, e_out});
        end
        if (!busy) gap = 0;
        else begin
            gap++;
            if (tick) begin
                if (exp_gap != 0) check("tick_gap", gap, exp_gap);
                gap = 0;
            end
        end
        if (done) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] s, input int d);
        cfg_we = 1'b1; cfg_addr = a; cfg_sel = s; cfg_dwell = DW_W'(d);
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [1:0] last, input logic lp, input int dv);
        cfg_last = last; loop_en = lp; div_load = DIV_W'(dv);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        int d0;
        int k;
        cyc(3);
        reset = 1'b0;
        cyc(1);

        // default table: four single-tick slots of sel 11
        d0 = done_cnt;
        go(2'd3, 1'b0, 0);
        cyc(8);
        check("default_done", done_cnt - d0, 1);

        // one-shot sequence
        wr(2'd0, 2'b00, 3);
        wr(2'd1, 2'b10, 2);
        exp_gap = 5;
        d0 = done_cnt;
        go(2'd1, 1'b0, 4);
        cyc(30);
        check("oneshot_done", done_cnt - d0, 1);
        exp_gap = 0;

        // loop wrap, every cycle a new slot
        wr(2'd0, 2'b00, 1); wr(2'd1, 2'b01, 1); wr(2'd2, 2'b10, 1); wr(2'd3, 2'b01, 1);
        d0 = done_cnt;
        go(2'd3, 1'b1, 0);
        cyc(20);
        check("loop_no_done", done_cnt - d0, 0);
        check("loop_busy", busy, 1);
        pulse_stop();
        cyc(2);

        // stop during slot 2, then restart
        wr(2'd0, 2'b00, 2); wr(2'd1, 2'b01, 2); wr(2'd2, 2'b10, 2); wr(2'd3, 2'b00, 2);
        go(2'd3, 1'b1, 1);
        k = 0;
        while (slot != 2'd2 && k < 50) begin
            cyc(1);
            k++;
        end
        check("reach_slot2", slot, 2);
        d0 = done_cnt;
        pulse_stop();
        check("stop_busy", busy, 0);
        check("stop_sel", wave_sel, 3);
        cyc(3);
        check("stop_no_done", done_cnt - d0, 0);
        go(2'd3, 1'b1, 1);
        check("restart_slot", slot, 0);
        check("restart_busy", busy, 1);
        pulse_stop();
        cyc(2);

        // dwell 0 plays as one tick
        wr(2'd0, 2'b01, 0);
        d0 = done_cnt;
        go(2'd0, 1'b0, 2);
        cyc(6);
        check("dwell0_done", done_cnt - d0, 1);

        // table write and start while busy are ignored
        wr(2'd0, 2'b00, 4);
        wr(2'd1, 2'b10, 1);
        d0 = done_cnt;
        go(2'd1, 1'b0, 0);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_sel = 2'b01; cfg_dwell = DW_W'(3);
        cyc(1);
        cfg_we = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(8);
        check("busy_write_done", done_cnt - d0, 1);

        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", busy, 0);
        cyc(2);

        // maximum prescale
        wr(2'd0, 2'b10, 3);
        exp_gap = 16;
        d0 = done_cnt;
        go(2'd0, 1'b0, 15);
        cyc(16 * 3 + 4);
        check("maxdiv_done", done_cnt - d0, 1);
        exp_gap = 0;

        // asynchronous reset mid-run, then table back to defaults
        wr(2'd0, 2'b01, 5);
        wr(2'd1, 2'b10, 5);
        go(2'd1, 1'b1, 0);
        cyc(3);
        #1 reset = 1'b1;
        #1;
        check("rst_wave_sel", wave_sel, 3);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_slot", slot, 0);
        check("rst_done", done, 0);
        cyc(2);
        reset = 1'b0;
        d0 = done_cnt;
        go(2'd3, 1'b0, 0);
        cyc(8);
        check("post_rst_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
